ram_stream_reader: RTL

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_if.sv | 30 +++
 rtl/ram_stream_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - RAM read port and output beat stream of ram_stream_reader
interface ram_stream_reader_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
);
  logic [ADDRESS_WIDTH-1:0] address_RD;
  logic [DATA_WIDTH-1:0]    ram_data;
  logic [DATA_WIDTH/2-1:0]  TX_DATA;
  logic                     TX_VALID;
  logic                     TX_READY;
  logic                     TX_LAST;

  modport master (
    output address_RD,
    input  ram_data,
    output TX_DATA,
    output TX_VALID,
    output TX_LAST,
    input  TX_READY
  );

  modport slave (
    input  address_RD,
    output ram_data,
    input  TX_DATA,
    input  TX_VALID,
    input  TX_LAST,
    output TX_READY
  );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams RAM words as two half-width beats (low half first)
// Optional trailing checksum beat: define RAM_STREAM_READER_CHECKSUM_EN.
module ram_stream_reader #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [ADDRESS_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDRESS_WIDTH-1:0] WORD_COUNT,
  output logic                     BUSY,
  output logic                     DONE,
  ram_stream_reader_if.master      bus
);
  localparam int HALF = DATA_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_LO,
    SEND_HI,
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    SEND_SUM,
`endif
    FINISH
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] remain_q;
  logic [DATA_WIDTH-1:0]    word_q;
  logic [HALF-1:0]          tx_data_q;
  logic                     tx_valid_q;
  logic                     tx_last_q;
  logic                     busy_q;
  logic                     done_q;

  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [ADDRESS_WIDTH-1:0] remain_d;
  logic                     last_word;

  assign addr_d    = addr_q + ADDRESS_WIDTH'(1);
  assign remain_d  = remain_q - ADDRESS_WIDTH'(1);
  assign last_word = (remain_q == ADDRESS_WIDTH'(1));

`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [HALF-1:0] sum_q;
  logic [HALF-1:0] sum_d;

  // The beat being handshaken is always the one held in tx_data_q.
  assign sum_d = sum_q + tx_data_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            busy_q <= 1'b1;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
            sum_q  <= '0;
`endif
            if (WORD_COUNT != '0) begin
              remain_q <= WORD_COUNT;
              addr_q   <= BASE_ADDR;
              state_q  <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end

        // RAM sampled address_RD on the falling edge, so its data is valid now.
        FETCH: begin
          word_q     <= bus.ram_data;
          tx_data_q  <= bus.ram_data[HALF-1:0];
          tx_valid_q <= 1'b1;
          tx_last_q  <= 1'b0;
          state_q    <= SEND_LO;
        end

        SEND_LO: begin
          if (bus.TX_READY) begin
`ifdef RAM_STREAM_READER_CHECKSUM_EN
            sum_q     <= sum_d;
`else
            tx_last_q <= last_word;
`endif
            tx_data_q <= word_q[DATA_WIDTH-1:HALF];
            state_q   <= SEND_HI;
          end
        end

        SEND_HI: begin
          if (bus.TX_READY) begin
            if (!last_word) begin
`ifdef RAM_STREAM_READER_CHECKSUM_EN
              sum_q    <= sum_d;
`endif
              addr_q     <= addr_d;
              remain_q   <= remain_d;
              tx_valid_q <= 1'b0;
              state_q    <= FETCH;
            end else begin
`ifdef RAM_STREAM_READER_CHECKSUM_EN
              tx_data_q <= sum_d;
              tx_last_q <= 1'b1;
              state_q   <= SEND_SUM;
`else
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FINISH;
`endif
            end
          end
        end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
        SEND_SUM: begin
          if (bus.TX_READY) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FINISH;
          end
        end
`endif

        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address_RD = addr_q;
  assign bus.TX_DATA    = tx_data_q;
  assign bus.TX_VALID   = tx_valid_q;
  assign bus.TX_LAST    = tx_last_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
endmodule
